pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS32 pipeline. Merges stage stall

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_mc_counter.sv | 41 ++++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline stall/flush sequencer
//
// Purpose : stall bit indices, controller state encodings, multi-cycle op
//           defaults, register-bus width and the reset-asserted level.
// Ports   : none (package)

package pipe_ctrl_pkg;

   localparam int REG_W   = 32;
   localparam int STALL_W = 6;

   localparam logic [REG_W-1:0] ZERO_WORD = '0;

   // rst is active-low
   localparam logic RST_ASSERTED = 1'b0;

   // stall vector bit positions, front of the pipe first
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam int MUL_CYCLES_DEF = 3;
   localparam int DIV_CYCLES_DEF = 32;

   typedef enum logic [1:0] {
      CTRL_RUN   = 2'd0,
      CTRL_BUSY  = 2'd1,
      CTRL_FLUSH = 2'd2
   } ctrl_state_t;

   // Hold every stage from pc up to and including stage 'top'; the result is
   // always a prefix so the first un-held stage downstream takes a bubble.
   function automatic logic [STALL_W-1:0] stall_upto(input int top);
      logic [STALL_W-1:0] m;
      m = '0;
      for (int i = 0; i < STALL_W; i++) begin
         m[i] = (i <= top);
      end
      return m;
   endfunction

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// rtl/pipe_ctrl_mc_counter.sv - loadable down-counter with zero flag for multi-cycle EX ops
//
// Purpose : counts the remaining EX cycles of a MULT/DIV operation.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-low reset
//           load  - load val into the counter
//           val   - value to load
//           clr   - force the counter to zero (wins over load)
//           zero  - counter currently equals zero

module pipe_ctrl_mc_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] val,
   input  logic             clr,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Only decrements while nonzero, so it never wraps and idles at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ASSERTED) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose : merges stage stall requests and multi-cycle EX occupancy into one
//           prefix-shaped stall vector, sequences exception flushes and holds
//           the redirect PC.
// Ports   : clk, rst (async active-low)
//           stallreq_id  - load-use hazard in ID
//           ex_start     - multi-cycle op enters EX (pulse)
//           ex_is_div    - ex_start is DIV/DIVU (else MULT/MULTU)
//           stallreq_mem - data memory not ready (level)
//           excp_valid   - exception committed in MEM
//           excp_vector  - handler address for excp_valid
//           stall        - hold bits [0]pc [1]if [2]id [3]ex [4]mem [5]wb
//           ex_busy      - multi-cycle op in progress
//           ex_done      - EX result valid this cycle (pulse)
//           flush        - clear all pipeline registers this cycle
//           new_pc       - redirect PC, valid while flush=1

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               ex_start,
   input  logic               ex_is_div,
   input  logic               stallreq_mem,
   input  logic               excp_valid,
   input  logic [REG_W-1:0]   excp_vector,
   output logic [STALL_W-1:0] stall,
   output logic               ex_busy,
   output logic               ex_done,
   output logic               flush,
   output logic [REG_W-1:0]   new_pc
);

   ctrl_state_t      state;
   logic             cnt_zero;
   logic             cnt_load;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_val;
   logic             excp_take;

   // FLUSH ignores a further exception; in RUN the exception also discards
   // any op issuing in the same cycle.
   assign excp_take = excp_valid && (state != CTRL_FLUSH);
   assign cnt_load  = (state == CTRL_RUN) && ex_start && !excp_valid;
   assign cnt_clr   = excp_take;
   assign cnt_val   = ex_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

   pipe_ctrl_mc_counter #(
      .CNT_W (CNT_W)
   ) u_mc_counter (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .val  (cnt_val),
      .clr  (cnt_clr),
      .zero (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ASSERTED) begin
         state  <= CTRL_RUN;
         new_pc <= ZERO_WORD;
      end else begin
         case (state)
            CTRL_RUN: begin
               if (excp_valid) begin
                  state  <= CTRL_FLUSH;
                  new_pc <= excp_vector;
               end else if (ex_start) begin
                  state <= CTRL_BUSY;
               end
            end
            CTRL_BUSY: begin
               if (excp_valid) begin
                  state  <= CTRL_FLUSH;
                  new_pc <= excp_vector;
               end else if (cnt_zero) begin
                  state <= CTRL_RUN;
               end
            end
            CTRL_FLUSH: begin
               state <= CTRL_RUN;
            end
            default: begin
               state <= CTRL_RUN;
            end
         endcase
      end
   end

   assign ex_busy = (state == CTRL_BUSY);
   assign ex_done = (state == CTRL_BUSY) && cnt_zero;
   assign flush   = (state == CTRL_FLUSH);

   // The issue cycle plus every BUSY cycle with cnt!=0 holds EX, giving
   // exactly N held cycles for an N-cycle op; the cnt==0 cycle releases it.
   always_comb begin
      stall = '0;
      if (state == CTRL_FLUSH) begin
         stall = '0;
      end else if (stallreq_mem) begin
         stall = stall_upto(STALL_MEM);
      end else if ((state == CTRL_RUN && ex_start) ||
                   (state == CTRL_BUSY && !cnt_zero)) begin
         stall = stall_upto(STALL_EX);
      end else if (stallreq_id) begin
         stall = stall_upto(STALL_ID);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_id;
   logic        ex_start;
   logic        ex_is_div;
   logic        stallreq_mem;
   logic        excp_valid;
   logic [31:0] excp_vector;
   logic [5:0]  stall;
   logic        ex_busy;
   logic        ex_done;
   logic        flush;
   logic [31:0] new_pc;

   int errors = 0;
   int checks = 0;

   pipe_ctrl #(
      .MUL_CYCLES (3),
      .DIV_CYCLES (32),
      .CNT_W      (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .ex_start     (ex_start),
      .ex_is_div    (ex_is_div),
      .stallreq_mem (stallreq_mem),
      .excp_valid   (excp_valid),
      .excp_vector  (excp_vector),
      .stall        (stall),
      .ex_busy      (ex_busy),
      .ex_done      (ex_done),
      .flush        (flush),
      .new_pc       (new_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; checks follow 3 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stallreq_id  = 1'b0;
      ex_start     = 1'b0;
      ex_is_div    = 1'b0;
      stallreq_mem = 1'b0;
      excp_valid   = 1'b0;
      excp_vector  = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #4;
      checks++;
      if ({stall, ex_busy, ex_done, flush} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs: got stall=%b busy=%b done=%b flush=%b want all 0",
                  stall, ex_busy, ex_done, flush);
      end
      checks++;
      if (new_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_new_pc: got %h want 00000000", new_pc);
      end
      next_cycle();
      rst = 1'b1;
   endtask

   task automatic test_reset_mid_op();
      next_cycle();
      ex_start = 1'b1; ex_is_div = 1'b1;
      for (int i = 1; i <= 27; i++) begin
         next_cycle();
         ex_start = 1'b0;
      end
      // cycle 27 after issue: BUSY with cnt=5
      #2;
      checks++;
      if (ex_busy !== 1'b1 || stall !== 6'b001111) begin
         errors++;
         $display("FAIL mid_op_busy: got busy=%b stall=%b want 1 001111", ex_busy, stall);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({stall, ex_busy, ex_done, flush} !== 9'b0 || new_pc !== 32'h0) begin
         errors++;
         $display("FAIL mid_op_reset: got stall=%b busy=%b done=%b flush=%b pc=%h want 0",
                  stall, ex_busy, ex_done, flush, new_pc);
      end
      next_cycle();
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         #3;
         checks++;
         if (ex_done !== 1'b0 || ex_busy !== 1'b0 || stall !== 6'b0) begin
            errors++;
            $display("FAIL after_reset_idle c%0d: got done=%b busy=%b stall=%b want 0 0 000000",
                     i, ex_done, ex_busy, stall);
         end
      end
   endtask

   task automatic test_mul();
      logic [5:0] exp_stall;
      for (int i = 0; i <= 4; i++) begin
         next_cycle();
         ex_start  = (i == 0);
         ex_is_div = 1'b0;
         #3;
         exp_stall = (i < 3) ? 6'b001111 : 6'b000000;
         checks++;
         if (stall !== exp_stall || ex_done !== (i == 3) || ex_busy !== (i >= 1 && i <= 3)) begin
            errors++;
            $display("FAIL mul c%0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                     i, stall, ex_done, ex_busy, exp_stall, (i == 3), (i >= 1 && i <= 3));
         end
      end
      ex_start = 1'b0;
   endtask

   task automatic test_mul_mem();
      logic [5:0] exp_stall;
      // mem stall on issue cycle and on the ex_done cycle
      for (int i = 0; i <= 4; i++) begin
         next_cycle();
         ex_start     = (i == 0);
         ex_is_div    = 1'b0;
         stallreq_mem = (i == 0 || i == 3);
         #3;
         exp_stall = (i == 0 || i == 3) ? 6'b011111 : (i < 3) ? 6'b001111 : 6'b000000;
         checks++;
         if (stall !== exp_stall || ex_done !== (i == 3)) begin
            errors++;
            $display("FAIL mul_mem c%0d: got stall=%b done=%b want stall=%b done=%b",
                     i, stall, ex_done, exp_stall, (i == 3));
         end
      end
      clear_inputs();
   endtask

   task automatic test_div_mem();
      logic [5:0] exp_stall;
      logic       mem;
      for (int i = 0; i <= 33; i++) begin
         next_cycle();
         mem          = (i >= 10 && i <= 12);
         ex_start     = (i == 0 || i == 5);   // second pulse lands in BUSY and is ignored
         ex_is_div    = 1'b1;
         stallreq_mem = mem;
         #3;
         exp_stall = mem ? 6'b011111 : (i < 32) ? 6'b001111 : 6'b000000;
         checks++;
         if (stall !== exp_stall || ex_done !== (i == 32) || ex_busy !== (i >= 1 && i <= 32)) begin
            errors++;
            $display("FAIL div c%0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                     i, stall, ex_done, ex_busy, exp_stall, (i == 32), (i >= 1 && i <= 32));
         end
      end
      clear_inputs();
   endtask

   task automatic test_excp_busy();
      next_cycle();
      ex_start = 1'b1; ex_is_div = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         ex_start = 1'b0;
      end
      next_cycle();
      excp_valid = 1'b1; excp_vector = 32'h0000_0020;
      #3;
      checks++;
      if (stall !== 6'b001111 || flush !== 1'b0) begin
         errors++;
         $display("FAIL excp_busy_req: got stall=%b flush=%b want 001111 0", stall, flush);
      end
      // FLUSH cycle: all inputs must be ignored
      next_cycle();
      excp_valid = 1'b1; excp_vector = 32'hBFC0_0380;
      ex_start = 1'b1; stallreq_mem = 1'b1; stallreq_id = 1'b1;
      #3;
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'h0000_0020 || stall !== 6'b0 ||
          ex_busy !== 1'b0 || ex_done !== 1'b0) begin
         errors++;
         $display("FAIL excp_flush: got flush=%b pc=%h stall=%b busy=%b done=%b want 1 00000020 000000 0 0",
                  flush, new_pc, stall, ex_busy, ex_done);
      end
      next_cycle();
      clear_inputs();
      #3;
      checks++;
      if (flush !== 1'b0 || ex_busy !== 1'b0 || stall !== 6'b0) begin
         errors++;
         $display("FAIL excp_return_run: got flush=%b busy=%b stall=%b want 0 0 000000",
                  flush, ex_busy, stall);
      end
      for (int i = 0; i < 32; i++) begin
         next_cycle();
         #3;
         checks++;
         if (ex_done !== 1'b0 || ex_busy !== 1'b0) begin
            errors++;
            $display("FAIL excp_no_done c%0d: got done=%b busy=%b want 0 0", i, ex_done, ex_busy);
         end
      end
   endtask

   task automatic test_stall_req();
      // {id, mem, start} per cycle and the expected stall
      logic [2:0] vec [0:7];
      logic [5:0] exp [0:7];
      vec[0] = 3'b100; exp[0] = 6'b000111;
      vec[1] = 3'b110; exp[1] = 6'b011111;
      vec[2] = 3'b010; exp[2] = 6'b011111;
      vec[3] = 3'b000; exp[3] = 6'b000000;
      vec[4] = 3'b101; exp[4] = 6'b001111;   // mul issue beats load-use
      vec[5] = 3'b100; exp[5] = 6'b001111;
      vec[6] = 3'b100; exp[6] = 6'b001111;
      vec[7] = 3'b100; exp[7] = 6'b000111;   // ex_done cycle: EX released
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         stallreq_id  = vec[i][2];
         stallreq_mem = vec[i][1];
         ex_start     = vec[i][0];
         ex_is_div    = 1'b0;
         #3;
         checks++;
         if (stall !== exp[i]) begin
            errors++;
            $display("FAIL stall_req c%0d: got %b want %b", i, stall, exp[i]);
         end
         checks++;
         if ((stall & (stall + 6'd1)) !== 6'b0) begin
            errors++;
            $display("FAIL stall_prefix c%0d: got %b want contiguous low-order ones", i, stall);
         end
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_excp_with_start();
      next_cycle();
      ex_start = 1'b1; ex_is_div = 1'b1;
      excp_valid = 1'b1; excp_vector = 32'h0000_0080;
      #3;
      checks++;
      if (ex_busy !== 1'b0 || flush !== 1'b0) begin
         errors++;
         $display("FAIL excp_start_issue: got busy=%b flush=%b want 0 0", ex_busy, flush);
      end
      next_cycle();
      clear_inputs();
      #3;
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'h0000_0080 || ex_busy !== 1'b0 || stall !== 6'b0) begin
         errors++;
         $display("FAIL excp_start_flush: got flush=%b pc=%h busy=%b stall=%b want 1 00000080 0 000000",
                  flush, new_pc, ex_busy, stall);
      end
      for (int i = 0; i < 34; i++) begin
         next_cycle();
         #3;
         checks++;
         if (ex_done !== 1'b0 || ex_busy !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL excp_start_discard c%0d: got done=%b busy=%b flush=%b want 0 0 0",
                     i, ex_done, ex_busy, flush);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_op();
      test_mul();
      test_mul_mem();
      test_div_mem();
      test_excp_busy();
      test_stall_req();
      test_excp_with_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
